// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Single outstanding request: one req&ready handshake is followed by exactly one rvalid.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/ifetch_unit.sv
// MIPS instruction fetch: owns the PC, issues one outstanding imem request at a time,
// and feeds decode through a registered IF/ID slot with stall hold and redirect flush.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                 clk,
    input  logic                 rstn,
    ifetch_unit_if.master        imem,
    output logic                 id_valid,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    input  logic                 id_stall,
    input  logic [1:0]           npc_op,
    input  logic [31:0]          br_pc,
    input  logic [15:0]          br_imm16,
    input  logic [25:0]          j_index,
    input  logic [31:0]          jr_target
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] seq_pc, target;
    logic        redirect, handshake, can_write, capture;
    logic        unused_jr_lo;

    assign redirect     = (npc_op != 2'b00);
    assign handshake    = imem.imem_req & imem.imem_ready;
    assign can_write    = ~id_valid | ~id_stall;
    assign seq_pc       = br_pc + 32'd4;
    assign unused_jr_lo = ^jr_target[1:0];

    always_comb begin
        target = seq_pc + {{14{br_imm16[15]}}, br_imm16, 2'b00};
        case (npc_op)
            2'b10:   target = {seq_pc[31:28], j_index, 2'b00};
            2'b11:   target = {jr_target[31:2], 2'b00};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) pc_nxt = target;
            end
            REQ: begin
                if (redirect) pc_nxt = target;
                // accepted request for the stale pc must have its response discarded
                if (handshake) state_nxt = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (redirect) begin
                        pc_nxt    = target;
                        state_nxt = REQ;
                    end else if (can_write) begin
                        capture   = 1'b1;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = REQ;
                    end
                end else if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (redirect) pc_nxt = target;
                if (imem.imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem.imem_req  = (state == REQ);
    assign imem.imem_addr = pc;

    // flush beats stall; a stalled slot otherwise holds
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_valid <= 1'b0;
            id_instr <= 32'd0;
            id_pc    <= 32'd0;
        end else if (redirect) begin
            id_valid <= 1'b0;
        end else if (capture) begin
            id_valid <= 1'b1;
            id_instr <= imem.imem_rdata;
            id_pc    <= pc;
        end else if (!id_stall) begin
            id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural instruction memory, fetch/decode scoreboard queues,
// a redirect-target vector table and hand-written stall/flush/reset sequences.
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr, id_pc;
    logic        id_stall = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic [31:0] br_pc = 32'd0;
    logic [15:0] br_imm16 = 16'd0;
    logic [25:0] j_index = 26'd0;
    logic [31:0] jr_target = 32'd0;

    int total = 0;
    int bad = 0;

    ifetch_unit_if bus();

    ifetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rstn(rstn), .imem(bus),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_stall(id_stall),
        .npc_op(npc_op), .br_pc(br_pc), .br_imm16(br_imm16), .j_index(j_index),
        .jr_target(jr_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // instruction memory: latency lat (0 = one cycle); rvalid held until the fetch unit requests again
    int          lat = 0;
    logic        ready_en = 1'b0, ready_gate = 1'b1;
    logic        rv_q, pend;
    int          cnt;
    logic [31:0] raddr;

    assign bus.imem_ready  = ready_en & ready_gate;
    assign bus.imem_rvalid = rv_q & ~bus.imem_req;
    assign bus.imem_rdata  = mem_word(raddr);

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rv_q <= 1'b0; pend <= 1'b0; cnt <= 0; raddr <= 32'd0;
        end else begin
            if (bus.imem_req) rv_q <= 1'b0;
            if (pend) begin
                if (cnt <= 1) begin rv_q <= 1'b1; pend <= 1'b0; end
                else cnt <= cnt - 1;
            end
            if (bus.imem_req && bus.imem_ready) begin
                raddr <= bus.imem_addr;
                if (lat == 0) rv_q <= 1'b1;
                else begin pend <= 1'b1; cnt <= lat; end
            end
        end
    end

    // scoreboard: expected fetch addresses and expected IF/ID pcs, pushed by the stimulus
    logic        sb_on = 1'b0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_id[$];
    logic        prev_v = 1'b0, prev_s = 1'b0;

    always @(posedge clk) begin
        #1;
        ready_gate = !(sb_on && exp_addr.size() == 0);
    end

    always @(negedge clk) begin
        if (rstn && sb_on) begin
            if (bus.imem_req && bus.imem_ready) begin
                if (exp_addr.size() == 0) chk("fetch_unexpected", bus.imem_addr, 32'hxxxx_xxxx);
                else chk("fetch_addr", bus.imem_addr, exp_addr.pop_front());
            end
            if (id_valid && !(prev_v && prev_s)) begin
                chk("id_instr", id_instr, mem_word(id_pc));
                if (exp_id.size() == 0) chk("id_unexpected", id_pc, 32'hxxxx_xxxx);
                else chk("id_pc", id_pc, exp_id.pop_front());
            end
        end
        prev_v = id_valid;
        prev_s = id_stall;
    end

    task automatic do_reset();
        rstn = 1'b0; npc_op = 2'b00; id_stall = 1'b0; ready_en = 1'b0; lat = 0; sb_on = 1'b0;
        exp_addr.delete(); exp_id.delete();
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic drain(input string nm);
        int k;
        for (k = 0; k < 60 && (exp_addr.size() != 0 || exp_id.size() != 0); k++) tick();
        chk(nm, (exp_addr.size() == 0 && exp_id.size() == 0), 1);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] bpc;
        logic [15:0] imm;
        logic [25:0] ji;
        logic [31:0] jr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int k;
        vecs[0] = '{2'b10, 32'h0000_3010, 16'h0000, 26'h0000C40, 32'h0,        32'h0000_3100};
        vecs[1] = '{2'b11, 32'h0,         16'h0000, 26'h0,        32'h0000_4007, 32'h0000_4004};
        vecs[2] = '{2'b01, 32'h0000_3008, 16'hFFFE, 26'h0,        32'h0,        32'h0000_3004};
        vecs[3] = '{2'b01, 32'hFFFF_FFF8, 16'h0001, 26'h0,        32'h0,        32'h0000_0000};
        vecs[4] = '{2'b01, 32'h0000_0000, 16'h8000, 26'h0,        32'h0,        32'hFFFE_0004};
        vecs[5] = '{2'b01, 32'h1000_0000, 16'h7FFF, 26'h0,        32'h0,        32'h1002_0000};
        vecs[6] = '{2'b10, 32'hEFFF_FFFC, 16'h0000, 26'h3FFFFFF,  32'h0,        32'hFFFF_FFFC};
        vecs[7] = '{2'b10, 32'hFFFF_FFFC, 16'h0000, 26'h0,        32'h0,        32'h0000_0000};
        vecs[8] = '{2'b11, 32'h0,         16'h0000, 26'h0,        32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[9] = '{2'b00, 32'h1234_5678, 16'h0040, 26'h1,        32'h0000_8000, 32'hFFFF_FFFC};

        // reset values, first request, first capture, then three sequential fetches
        do_reset();
        chk("rst_req", bus.imem_req, 0);
        chk("rst_addr", bus.imem_addr, 32'h0000_3000);
        chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_idpc", id_pc, 0);
        exp_addr = '{32'h3000, 32'h3004, 32'h3008};
        exp_id   = '{32'h3000, 32'h3004, 32'h3008};
        sb_on = 1'b1; ready_en = 1'b1;
        tick();
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 32'h3000);
        tick();
        chk("first_rvalid", bus.imem_rvalid, 1);
        chk("first_notyet", id_valid, 0);
        tick();
        chk("first_valid", id_valid, 1);
        chk("first_idpc", id_pc, 32'h3000);
        chk("second_addr", bus.imem_addr, 32'h3004);
        drain("seq_drain");

        // decode stall holding 0x3004's word; the held rvalid is taken once the stall drops
        do_reset();
        exp_addr = '{32'h3000, 32'h3004, 32'h3008};
        exp_id   = '{32'h3000, 32'h3004, 32'h3008};
        sb_on = 1'b1; ready_en = 1'b1;
        for (k = 0; k < 20 && !(id_valid && id_pc == 32'h3004); k++) tick();
        chk("stall_reach", id_pc, 32'h3004);
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", id_valid, 1);
            chk("stall_idpc", id_pc, 32'h3004);
            chk("stall_instr", id_instr, mem_word(32'h3004));
        end
        chk("stall_rv_held", bus.imem_rvalid, 1);
        id_stall = 1'b0;
        drain("stall_drain");

        // branch while waiting on a slow response: flush slot, drop word, refetch target
        do_reset();
        id_stall = 1'b1; ready_en = 1'b1;
        for (k = 0; k < 20 && !id_valid; k++) tick();
        chk("br_prefill", id_valid, 1);
        lat = 3;
        for (k = 0; k < 10 && !bus.imem_req; k++) tick();
        tick();
        ready_en = 1'b0;
        chk("br_inwait", bus.imem_req, 0);
        chk("br_norv", bus.imem_rvalid, 0);
        npc_op = 2'b01; br_pc = 32'h3008; br_imm16 = 16'hFFFE;
        tick();
        npc_op = 2'b00;
        chk("br_flush", id_valid, 0);
        chk("br_drop_noreq", bus.imem_req, 0);
        for (k = 0; k < 10 && !bus.imem_req; k++) tick();
        chk("br_req", bus.imem_req, 1);
        chk("br_addr", bus.imem_addr, 32'h3004);
        chk("br_nocapture", id_valid, 0);

        // redirect targets applied in REQ with memory not ready
        do_reset();
        tick();
        foreach (vecs[i]) begin
            npc_op = vecs[i].op; br_pc = vecs[i].bpc; br_imm16 = vecs[i].imm;
            j_index = vecs[i].ji; jr_target = vecs[i].jr;
            tick();
            npc_op = 2'b00;
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp);
            chk($sformatf("vec%0d_req", i), bus.imem_req, 1);
        end

        // sequential pc wraps from the top of memory to zero
        exp_addr = '{32'hFFFF_FFFC, 32'h0000_0000};
        exp_id   = '{32'hFFFF_FFFC, 32'h0000_0000};
        sb_on = 1'b1; ready_en = 1'b1;
        drain("wrap_drain");

        // redirect in the same cycle as rvalid while decode is stalled
        do_reset();
        id_stall = 1'b1; ready_en = 1'b1;
        for (k = 0; k < 20 && !id_valid; k++) tick();
        for (k = 0; k < 20 && !bus.imem_rvalid; k++) tick();
        chk("rvr_rv", bus.imem_rvalid, 1);
        chk("rvr_held", id_pc, 32'h3000);
        ready_en = 1'b0;
        npc_op = 2'b11; jr_target = 32'h0000_5000;
        tick();
        npc_op = 2'b00;
        chk("rvr_flush", id_valid, 0);
        chk("rvr_req", bus.imem_req, 1);
        chk("rvr_addr", bus.imem_addr, 32'h5000);
        id_stall = 1'b0;
        tick(); tick();
        chk("rvr_nocapture", id_valid, 0);

        // asynchronous reset while a response is outstanding
        do_reset();
        id_stall = 1'b1; ready_en = 1'b1;
        for (k = 0; k < 20 && !id_valid; k++) tick();
        lat = 5;
        for (k = 0; k < 10 && !bus.imem_req; k++) tick();
        tick();
        chk("mid_inwait", bus.imem_req, 0);
        #2 rstn = 1'b0;
        #1;
        chk("mid_req", bus.imem_req, 0);
        chk("mid_addr", bus.imem_addr, 32'h3000);
        chk("mid_valid", id_valid, 0);
        chk("mid_instr", id_instr, 0);
        chk("mid_idpc", id_pc, 0);
        id_stall = 1'b0; lat = 0;
        tick();
        rstn = 1'b1;
        tick();
        chk("restart_req", bus.imem_req, 1);
        chk("restart_addr", bus.imem_addr, 32'h3000);
        tick(); tick();
        chk("restart_valid", id_valid, 1);
        chk("restart_idpc", id_pc, 32'h3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
